// File: rtl/rv32i_ctrl_pipe.sv
// RV32I ID-stage control for a five-stage pipeline: decode into the ID/EX register,
// load-use / RAW hazard detection, EX-stage forwarding selects and saturating perf counters.
module rv32i_ctrl_pipe #(
  parameter int unsigned FWD_EN = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_d,
  input  logic             valid_d,
  input  logic             ex_pc_src,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic             ex_alu_a_pc,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic             ex_jalr,
  output logic [1:0]       ex_result_src,
  output logic [3:0]       ex_alu_ctrl,
  output logic [2:0]       ex_imm_src,
  output logic [2:0]       ex_funct3,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  localparam logic [3:0] ALU_SLU = 4'b1001;
  localparam logic [3:0] ALU_PSB = 4'b1010;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       alu_a_pc;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [1:0] result_src;
    logic [3:0] alu_ctrl;
    logic [2:0] imm_src;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctrl_t;

  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1_d, rs2_d;
  logic       use_rs1, use_rs2, illegal;
  ctrl_t      dec, ex_d, ex_q;
  logic       load_use, raw_any, hazard, stall_c;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q, ill_cnt_d, ill_cnt_q;

  assign opcode = instr_d[6:0];
  assign f3     = instr_d[14:12];
  assign f7     = instr_d[31:25];
  assign rs1_d  = instr_d[19:15];
  assign rs2_d  = instr_d[24:20];

  // Main decoder: control word plus which source fields are architecturally read
  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = alu_map(f3, instr_d[30]);
        illegal = !((f7 == F7_ZERO) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OP_I: begin
        use_rs1 = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_I;
        if (f3 == 3'b001) begin
          dec.alu_ctrl = ALU_SLL;
          illegal = (f7 != F7_ZERO);
        end else if (f3 == 3'b101) begin
          dec.alu_ctrl = instr_d[30] ? ALU_SRA : ALU_SRL;
          illegal = (f7 != F7_ZERO) && (f7 != F7_ALT);
        end else begin
          dec.alu_ctrl = alu_map(f3, 1'b0);
        end
      end
      OP_LOAD: begin
        use_rs1 = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
        dec.imm_src    = IMM_I;
        dec.alu_ctrl   = ALU_ADD;
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_S;
        dec.alu_ctrl  = ALU_ADD;
        illegal = (f3 > 3'b010);
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec.branch   = 1'b1;
        dec.imm_src  = IMM_B;
        dec.alu_ctrl = ALU_SUB;
        illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_U;
        dec.alu_ctrl  = ALU_PSB;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_a_pc  = 1'b1;
        dec.imm_src   = IMM_U;
        dec.alu_ctrl  = ALU_ADD;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        dec.imm_src    = IMM_J;
      end
      OP_JALR: begin
        use_rs1 = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.jump       = 1'b1;
        dec.jalr       = 1'b1;
        dec.result_src = 2'b10;
        dec.imm_src    = IMM_I;
        dec.alu_ctrl   = ALU_ADD;
        illegal = (f3 != 3'b000);
      end
      default: illegal = 1'b1;
    endcase
    dec.valid  = 1'b1;
    dec.funct3 = f3;
    dec.rs1    = use_rs1 ? rs1_d : 5'd0;
    dec.rs2    = use_rs2 ? rs2_d : 5'd0;
    dec.rd     = dec.reg_write ? instr_d[11:7] : 5'd0;
  end

  // Hazard detection; x0 and unused fields are excluded via the zeroed rs fields
  always_comb begin
    load_use = ex_q.valid && (ex_q.result_src == 2'b01) && (ex_q.rd != 5'd0) &&
               (((dec.rs1 != 5'd0) && (dec.rs1 == ex_q.rd)) ||
                ((dec.rs2 != 5'd0) && (dec.rs2 == ex_q.rd)));
    raw_any  = 1'b0;
    if (FWD_EN == 0) begin
      if (ex_q.valid && ex_q.reg_write && (ex_q.rd != 5'd0) &&
          ((dec.rs1 == ex_q.rd) || (dec.rs2 == ex_q.rd)))
        raw_any = 1'b1;
      if (mem_reg_write && (mem_rd != 5'd0) && ((dec.rs1 == mem_rd) || (dec.rs2 == mem_rd)))
        raw_any = 1'b1;
      if (wb_reg_write && (wb_rd != 5'd0) && ((dec.rs1 == wb_rd) || (dec.rs2 == wb_rd)))
        raw_any = 1'b1;
    end
    hazard  = valid_d && (load_use || raw_any);
    stall_c = hazard && !ex_pc_src;
  end

  assign stall_f = stall_c;
  assign stall_d = stall_c;
  assign flush_d = ex_pc_src;

  // ID/EX next value: bubble on stall, flush or empty slot; illegal carries a marker opcode
  always_comb begin
    ex_d = dec;
    if (!valid_d || stall_c || ex_pc_src) begin
      ex_d = '0;
    end else if (illegal) begin
      ex_d = '0;
      ex_d.alu_ctrl = ALU_ILL;
    end
  end

  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if ((FWD_EN != 0) && ex_q.valid) begin
      if (ex_q.rs1 != 5'd0) begin
        if (mem_reg_write && (mem_rd == ex_q.rs1))    fwd_a_e = 2'b10;
        else if (wb_reg_write && (wb_rd == ex_q.rs1)) fwd_a_e = 2'b01;
      end
      if (ex_q.rs2 != 5'd0) begin
        if (mem_reg_write && (mem_rd == ex_q.rs2))    fwd_b_e = 2'b10;
        else if (wb_reg_write && (wb_rd == ex_q.rs2)) fwd_b_e = 2'b01;
      end
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    ill_cnt_d   = ill_cnt_q;
    if (stall_c && !(&stall_cnt_q))  stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ex_pc_src && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (valid_d && illegal && !stall_c && !ex_pc_src && !(&ill_cnt_q))
      ill_cnt_d = ill_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      ill_cnt_q   <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_alu_a_pc   = ex_q.alu_a_pc;
  assign ex_branch     = ex_q.branch;
  assign ex_jump       = ex_q.jump;
  assign ex_jalr       = ex_q.jalr;
  assign ex_result_src = ex_q.result_src;
  assign ex_alu_ctrl   = ex_q.alu_ctrl;
  assign ex_imm_src    = ex_q.imm_src;
  assign ex_funct3     = ex_q.funct3;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
  assign illegal_cnt   = ill_cnt_q;

endmodule
